// File: rtl/tmds_channel_decoder_if.sv
// Signal bundle for one TMDS channel decoder:
// raw symbols in, decoded byte/control and alignment status out.
interface tmds_channel_decoder_if;
  logic [9:0] symbol_in;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;
  logic       lock_lost;

  modport master (
    output symbol_in,
    input  data,
    input  ctrl,
    input  de,
    input  locked,
    input  bit_offset,
    input  lock_lost
  );

  modport slave (
    input  symbol_in,
    output data,
    output ctrl,
    output de,
    output locked,
    output bit_offset,
    output lock_lost
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment search on control tokens,
// lock tracking, and 10b-to-8b video / control decode.
module tmds_channel_decoder #(
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOCK_TOKENS   = 8,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tmds_channel_decoder_if.slave bus
);

  localparam logic [12:0] SRCH_LAST = 13'(SEARCH_WINDOW - 1);
  localparam logic [12:0] LOSS_LAST = 13'(LOSS_WINDOW - 1);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_TOKENS);

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  sym_d1;
  logic [9:0]  sym_d2;
  logic [19:0] window;
  logic [9:0]  aligned;
  logic [12:0] timer;
  logic [12:0] timer_nxt;
  logic [3:0]  count;
  logic [3:0]  count_nxt;
  logic [3:0]  offset;
  logic [3:0]  offset_nxt;
  logic        is_tok;
  logic [1:0]  tok_val;
  logic        slip;
  logic        lost;
  logic        lk;
  logic [7:0]  vd;
  logic [7:0]  vid;

  logic [7:0]  data_q;
  logic [1:0]  ctrl_q;
  logic        de_q;
  logic        locked_q;
  logic        lost_q;

  // Older symbol sits in the low half, so bit 0 is the earliest bit.
  assign window  = {sym_d1, sym_d2};
  assign aligned = window[{1'b0, offset} +: 10];

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    unique case (aligned)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    vd     = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    vid    = '0;
    vid[0] = vd[0];
    for (int i = 1; i < 8; i++) begin
      vid[i] = aligned[8] ? (vd[i] ^ vd[i-1])
                          : ~(vd[i] ^ vd[i-1]);
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = count;
    slip      = 1'b0;
    lost      = 1'b0;
    unique case (state)
      SEARCH: begin
        if (is_tok) begin
          state_nxt = CONFIRM;
          count_nxt = 4'd1;
          timer_nxt = '0;
        end else if (timer == SRCH_LAST) begin
          slip      = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 13'd1;
        end
      end
      CONFIRM: begin
        if (is_tok) begin
          count_nxt = count + 4'd1;
          if (count_nxt == LOCK_N) begin
            state_nxt = LOCKED;
          end
        end else begin
          state_nxt = SEARCH;
          timer_nxt = '0;
          count_nxt = '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          timer_nxt = '0;
        end else if (timer == LOSS_LAST) begin
          state_nxt = SEARCH;
          lost      = 1'b1;
          slip      = 1'b1;
          timer_nxt = '0;
          count_nxt = '0;
        end else begin
          timer_nxt = timer + 13'd1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        timer_nxt = '0;
        count_nxt = '0;
      end
    endcase
    offset_nxt = offset;
    if (slip) begin
      offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    end
  end

  // Outputs follow the state entered on this edge.
  assign lk = (state_nxt == LOCKED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_d1 <= '0;
      sym_d2 <= '0;
      state  <= SEARCH;
      timer  <= '0;
      count  <= '0;
      offset <= '0;
    end else begin
      sym_d1 <= bus.symbol_in;
      sym_d2 <= sym_d1;
      state  <= state_nxt;
      timer  <= timer_nxt;
      count  <= count_nxt;
      offset <= offset_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      locked_q <= lk;
      lost_q   <= lost;
      if (!lk) begin
        data_q <= '0;
        ctrl_q <= '0;
        de_q   <= 1'b0;
      end else if (is_tok) begin
        data_q <= '0;
        ctrl_q <= tok_val;
        de_q   <= 1'b0;
      end else begin
        data_q <= vid;
        de_q   <= 1'b1;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.de         = de_q;
  assign bus.locked     = locked_q;
  assign bus.bit_offset = offset;
  assign bus.lock_lost  = lost_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: bit-stream reference model,
// directed alignment/lock scenarios and randomized traffic.
module tb_tmds_channel_decoder;

  localparam int SW = 1024;
  localparam int LT = 8;
  localparam int LW = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tmds_channel_decoder_if bus();

  tmds_channel_decoder #(
    .SEARCH_WINDOW(SW),
    .LOCK_TOKENS(LT),
    .LOSS_WINDOW(LW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] m_d1, m_d2;
  int m_mode, m_tmr, m_cnt, m_off;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic m_de, m_locked, m_lost;
  logic [9:0] prev_w;

  function automatic int tok_of(input logic [9:0] a);
    case (a)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] vdec(input logic [9:0] a);
    logic [7:0] d, t;
    d = a[9] ? ~a[7:0] : a[7:0];
    t = d ^ {d[6:0], 1'b0};
    if (!a[8]) t = ~t;
    t[0] = d[0];
    return t;
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0;
    m_mode = 0; m_tmr = 0; m_cnt = 0; m_off = 0;
    m_data = '0; m_ctrl = '0; m_de = 0; m_locked = 0; m_lost = 0;
  endtask

  // Mode 0 = hunting, 1 = counting tokens, 2 = locked.
  task automatic model_edge(input logic [9:0] s);
    logic [19:0] w;
    logic [9:0] a;
    int tv;
    bit adv;
    w = {m_d1, m_d2};
    a = 10'(w >> m_off);
    tv = tok_of(a);
    adv = 0;
    m_lost = 0;
    if (m_mode == 0) begin
      if (tv >= 0) begin m_mode = 1; m_cnt = 1; m_tmr = 0; end
      else if (m_tmr == SW - 1) begin adv = 1; m_tmr = 0; end
      else m_tmr++;
    end else if (m_mode == 1) begin
      if (tv >= 0) begin
        m_cnt++;
        if (m_cnt == LT) m_mode = 2;
      end else begin
        m_mode = 0; m_tmr = 0;
      end
    end else begin
      if (tv >= 0) m_tmr = 0;
      else if (m_tmr == LW - 1) begin
        m_mode = 0; m_lost = 1; adv = 1; m_tmr = 0;
      end else m_tmr++;
    end
    m_locked = (m_mode == 2);
    if (!m_locked) begin
      m_data = 0; m_ctrl = 0; m_de = 0;
    end else if (tv >= 0) begin
      m_data = 0; m_ctrl = 2'(tv); m_de = 0;
    end else begin
      m_data = vdec(a); m_de = 1;
    end
    if (adv) m_off = (m_off + 1) % 10;
    m_d2 = m_d1;
    m_d1 = s;
  endtask

  task automatic check_model();
    vectors++;
    if (bus.data !== m_data || bus.ctrl !== m_ctrl || bus.de !== m_de ||
        bus.locked !== m_locked || bus.lock_lost !== m_lost ||
        int'(bus.bit_offset) != m_off) begin
      errors++;
      $display("FAIL model cyc=%0d: dut data=%h ctrl=%0d de=%b lk=%b off=%0d lost=%b, want data=%h ctrl=%0d de=%b lk=%b off=%0d lost=%b",
               cyc, bus.data, bus.ctrl, bus.de, bus.locked, bus.bit_offset,
               bus.lock_lost, m_data, m_ctrl, m_de, m_locked, m_off, m_lost);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] s);
    bus.symbol_in = s;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(s);
    check_model();
  endtask

  // Emit word w into the bit stream delayed by r bit positions.
  task automatic send_word(input logic [9:0] w, input int r);
    logic [19:0] p;
    p = {w, prev_w};
    prev_w = w;
    step(10'(p >> (10 - r)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_lit("rst_data", int'(bus.data), 0);
    check_lit("rst_ctrl", int'(bus.ctrl), 0);
    check_lit("rst_de", int'(bus.de), 0);
    check_lit("rst_locked", int'(bus.locked), 0);
    check_lit("rst_offset", int'(bus.bit_offset), 0);
    check_lit("rst_lost", int'(bus.lock_lost), 0);
    model_reset();
    prev_w = '0;
    cyc = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int r;
    int n;
    logic [9:0] w;
    bus.symbol_in = '0;
    prev_w = '0;
    model_reset();

    // Aligned lock and first video bytes.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      send_word(10'h354, 0);
      if (i == 9) check_lit("lock_early", int'(bus.locked), 0);
      if (i == 10) begin
        check_lit("lock_at8", int'(bus.locked), 1);
        check_lit("lock_de", int'(bus.de), 0);
        check_lit("lock_ctrl", int'(bus.ctrl), 0);
      end
    end
    send_word(10'h2FF, 0);
    send_word(10'h100, 0);
    send_word(10'h354, 0);
    check_lit("vid_2ff", int'(bus.data), 8'hFE);
    check_lit("vid_2ff_de", int'(bus.de), 1);
    send_word(10'h354, 0);
    check_lit("vid_100", int'(bus.data), 8'h00);
    check_lit("vid_100_de", int'(bus.de), 1);

    // Loss of lock after a long run without tokens.
    pulses = 0;
    for (int i = 0; i < LW + 4; i++) begin
      send_word(10'h2FF, 0);
      if (bus.lock_lost) pulses++;
    end
    check_lit("loss_pulses", pulses, 1);
    check_lit("loss_locked", int'(bus.locked), 0);
    check_lit("loss_de", int'(bus.de), 0);
    check_lit("loss_offset", int'(bus.bit_offset), 1);

    // Control tokens while locked, then reset mid-stream.
    do_reset();
    for (int i = 1; i <= 12; i++) send_word(10'h354, 0);
    send_word(10'h154, 0);
    send_word(10'h2AB, 0);
    send_word(10'h2FF, 0);
    check_lit("ctrl_10", int'(bus.ctrl), 2);
    check_lit("ctrl_10_de", int'(bus.de), 0);
    send_word(10'h354, 0);
    check_lit("ctrl_11", int'(bus.ctrl), 3);
    check_lit("ctrl_11_de", int'(bus.de), 0);
    send_word(10'h2FF, 0);
    do_reset();
    check_lit("rel_locked", int'(bus.locked), 0);

    // Interrupted confirmation restarts the token count.
    for (int i = 0; i < 5; i++) send_word(10'h0AB, 0);
    send_word(10'h2FF, 0);
    for (int i = 0; i < 7; i++) send_word(10'h354, 0);
    send_word(10'h2FF, 0);
    send_word(10'h2FF, 0);
    check_lit("intr_locked", int'(bus.locked), 0);
    check_lit("intr_offset", int'(bus.bit_offset), 0);

    // Stream delayed by 3 bits: offset walks 0..3 then locks.
    do_reset();
    for (int i = 1; i <= 3100; i++) begin
      send_word(10'h354, 3);
      if (i == SW - 1) check_lit("mis_off0", int'(bus.bit_offset), 0);
      if (i == SW) check_lit("mis_off1", int'(bus.bit_offset), 1);
      if (i == 2 * SW) check_lit("mis_off2", int'(bus.bit_offset), 2);
      if (i == 3 * SW) check_lit("mis_off3", int'(bus.bit_offset), 3);
    end
    send_word(10'h2FF, 3);
    send_word(10'h100, 3);
    send_word(10'h354, 3);
    check_lit("mis_data_fe", int'(bus.data), 8'hFE);
    send_word(10'h354, 3);
    check_lit("mis_data_00", int'(bus.data), 8'h00);
    check_lit("mis_de", int'(bus.de), 1);
    check_lit("mis_locked", int'(bus.locked), 1);
    check_lit("mis_offset", int'(bus.bit_offset), 3);

    // Randomized traffic at random stream delays.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      r = $urandom_range(0, 9);
      n = 0;
      while (n < 3000) begin
        int len;
        len = $urandom_range(1, 14);
        for (int k = 0; k < len; k++) begin
          case ($urandom_range(0, 3))
            0: w = 10'h354;
            1: w = 10'h0AB;
            2: w = 10'h154;
            default: w = 10'h2AB;
          endcase
          send_word(w, r);
          n++;
        end
        len = ($urandom_range(0, 9) == 0) ? 700 : $urandom_range(1, 40);
        for (int k = 0; k < len; k++) begin
          send_word(10'($urandom), r);
          n++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
